// File: rtl/fabric_frame_loader.sv
// Configuration frame loader: sync/command/payload stream in, FrameData rows and one-hot FrameStrobe out.
// Optional build macro FRAME_LOADER_CHECKSUM_EN adds a trailing XOR checksum word per frame.
module fabric_frame_loader #(
    parameter int MaxFramePerCol  = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int NumCols         = 4
) (
    input  logic                                 UserCLK,
    input  logic                                 Rst,
    input  logic [31:0]                          WriteData,
    input  logic                                 WriteValid,
    output logic                                 WriteReady,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramePerCol*NumCols-1:0]    FrameStrobe,
    output logic                                 ConfigDone,
    output logic                                 Error
);

    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
    localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int ColW    = (NumCols > 1) ? $clog2(NumCols) : 1;
    localparam int FrmW    = (MaxFramePerCol > 1) ? $clog2(MaxFramePerCol) : 1;
    localparam int StrobeW = MaxFramePerCol * NumCols;
    localparam logic [RowW-1:0] LastRow  = RowW'(NumRows - 1);
    localparam logic [7:0]      ColLimit = 8'(NumCols);
    localparam logic [7:0]      FrmLimit = 8'(MaxFramePerCol);

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HUNT, CMD, DATA, CHECK, STROBE} state_t;
`else
    typedef enum logic [1:0] {HUNT, CMD, DATA, STROBE} state_t;
`endif

    state_t                     state, stateNext;
    logic [FrameBitsPerRow-1:0] rowData [NumRows];
    logic [RowW-1:0]            rowIdx;
    logic [ColW-1:0]            colSel;
    logic [FrmW-1:0]            frameSel;
    logic [StrobeW-1:0]         strobeOneHot;
    logic                       accept, isSync;
    logic                       latchCmd, loadRow, setDone, clearDone, setError;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] xorAcc;
`endif

    assign WriteReady   = !Rst && (state != STROBE);
    assign accept       = WriteValid && WriteReady;
    assign isSync       = (WriteData == SyncWord);
    assign strobeOneHot = StrobeW'(1) << (int'(colSel) * MaxFramePerCol + int'(frameSel));

    for (genvar r = 0; r < NumRows; r++) begin : g_rows
        assign FrameData[FrameBitsPerRow*r +: FrameBitsPerRow] = rowData[r];
    end

    // NOTE: every output of this block gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        stateNext = state;
        latchCmd  = 1'b0;
        loadRow   = 1'b0;
        setDone   = 1'b0;
        clearDone = 1'b0;
        setError  = 1'b0;
        case (state)
            HUNT: begin
                if (accept && isSync) begin
                    stateNext = CMD;
                    clearDone = 1'b1;
                end
            end
            CMD: begin
                if (accept && !isSync) begin
                    if (WriteData[31:24] == 8'h01 && WriteData[23:16] < ColLimit
                            && WriteData[15:8] < FrmLimit) begin
                        latchCmd  = 1'b1;
                        stateNext = DATA;
                    end else if (WriteData[31:24] == 8'h02) begin
                        setDone   = 1'b1;
                        stateNext = HUNT;
                    end else begin
                        setError  = 1'b1;
                        stateNext = HUNT;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    loadRow = 1'b1;
                    if (rowIdx == LastRow) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                        stateNext = CHECK;
`else
                        stateNext = STROBE;
`endif
                    end
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (WriteData == xorAcc) begin
                        stateNext = STROBE;
                    end else begin
                        setError  = 1'b1;
                        stateNext = CMD;
                    end
                end
            end
`endif
            STROBE:  stateNext = CMD;
            default: stateNext = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge UserCLK) begin
        if (Rst) begin
            state       <= HUNT;
            rowIdx      <= '0;
            colSel      <= '0;
            frameSel    <= '0;
            FrameStrobe <= '0;
            ConfigDone  <= 1'b0;
            Error       <= 1'b0;
            // NOTE: row storage is reset on purpose: a frame aborted by reset must not leave partial rows visible.
            for (int r = 0; r < NumRows; r++) rowData[r] <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            xorAcc      <= '0;
`endif
        end else begin
            state       <= stateNext;
            FrameStrobe <= (stateNext == STROBE) ? strobeOneHot : '0;
            if (setDone)        ConfigDone <= 1'b1;
            else if (clearDone) ConfigDone <= 1'b0;
            if (setError)       Error <= 1'b1;
            if (latchCmd) begin
                colSel   <= WriteData[16 +: ColW];
                frameSel <= WriteData[8 +: FrmW];
                rowIdx   <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                xorAcc   <= '0;
`endif
            end
            if (loadRow) begin
                rowData[rowIdx] <= WriteData;
                rowIdx          <= rowIdx + 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                xorAcc          <= xorAcc ^ WriteData;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fabric_frame_loader.sv
// Scoreboard bench for fabric_frame_loader: expected strobes/rows queued at stimulus time, popped on each strobe.
// The checksum scenario runs only when FRAME_LOADER_CHECKSUM_EN is defined.
module tb_fabric_frame_loader;

    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

    logic         UserCLK = 1'b0;
    logic         Rst = 1'b1;
    logic [31:0]  WriteData = '0;
    logic         WriteValid = 1'b0;
    logic         WriteReady;
    logic [127:0] FrameData;
    logic [127:0] FrameStrobe;
    logic         ConfigDone;
    logic         Error;

    fabric_frame_loader #(
        .MaxFramePerCol (32),
        .FrameBitsPerRow(32),
        .NumRows        (4),
        .NumCols        (4)
    ) dut (
        .UserCLK    (UserCLK),
        .Rst        (Rst),
        .WriteData  (WriteData),
        .WriteValid (WriteValid),
        .WriteReady (WriteReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .ConfigDone (ConfigDone),
        .Error      (Error)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct packed {
        logic [127:0] strobe;
        logic [127:0] data;
    } sbItem_t;

    sbItem_t sbQ [$];
    int numTests = 0;
    int numFails = 0;
    int cycleCnt = 0;
    int lastAcceptCyc = 0;

    always @(posedge UserCLK) cycleCnt <= cycleCnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        numTests++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] strobeBit(input int col, input int frm);
        logic [127:0] v;
        v = '0;
        v[col*32 + frm] = 1'b1;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge UserCLK);
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic sendWord(input logic [31:0] w);
        int budget = 0;
        WriteData  = w;
        WriteValid = 1'b1;
        while (WriteReady !== 1'b1 && budget < 16) begin
            @(negedge UserCLK);
            budget++;
        end
        if (budget >= 16) check("ready_timeout", WriteReady, 1);
        lastAcceptCyc = cycleCnt + 1;
        @(negedge UserCLK);
        WriteValid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] col, input logic [7:0] frm, input logic [127:0] rows,
                             input int maxGap, input logic [31:0] csumFlip);
        sbItem_t item;
`ifdef FRAME_LOADER_CHECKSUM_EN
        logic [31:0] csum = '0;
`endif
        if (csumFlip == 0) begin
            item.strobe = strobeBit(int'(col), int'(frm));
            item.data   = rows;
            sbQ.push_back(item);
        end
        idle($urandom_range(0, maxGap));
        sendWord({8'h01, col, frm, 8'h00});
        for (int r = 0; r < 4; r++) begin
            idle($urandom_range(0, maxGap));
            sendWord(rows[32*r +: 32]);
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum = csum ^ rows[32*r +: 32];
`endif
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        idle($urandom_range(0, maxGap));
        sendWord(csum ^ csumFlip);
`endif
    endtask

    // Any strobe must match the oldest queued expectation and land right after the last accepted word.
    always @(negedge UserCLK) begin : monitor
        sbItem_t item;
        if (FrameStrobe !== '0) begin
            if (sbQ.size() == 0) begin
                check("spurious_strobe", FrameStrobe, '0);
            end else begin
                item = sbQ.pop_front();
                check("strobe_bits", FrameStrobe, item.strobe);
                check("strobe_rows", FrameData, item.data);
                check("strobe_cycle", cycleCnt, lastAcceptCyc);
                check("ready_in_strobe", WriteReady, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rowsA, rowsB, rowsC, rowsT1;
        rowsT1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rowsA  = {$urandom, $urandom, $urandom, $urandom};
        rowsB  = {$urandom, $urandom, $urandom, $urandom};
        rowsC  = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};

        // Reset state
        idle(3);
        check("ready_in_reset", WriteReady, 0);
        Rst = 1'b0;
        @(negedge UserCLK);
        check("rst_data", FrameData, '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_done", ConfigDone, 0);
        check("rst_error", Error, 0);
        check("rst_ready_after", WriteReady, 1);

        // Garbage before sync, then END and a clearing sync
        sendWord(32'h0000_0000);
        sendWord(32'hDEAD_BEEF);
        check("garbage_error", Error, 0);
        check("garbage_done", ConfigDone, 0);
        sendWord(SyncWord);
        sendWord(32'h0200_0000);
        check("end_done", ConfigDone, 1);
        check("end_error", Error, 0);
        sendWord(SyncWord);
        check("sync_clears_done", ConfigDone, 0);

        // Basic frame: column 2, frame 5
        sendFrame(8'd2, 8'd5, rowsT1, 0, 32'h0);
        idle(3);
        check("t1_rows_hold", FrameData, rowsT1);

        // Column out of range, then words ignored in HUNT
        sendWord(32'h0104_0000);
        check("badcol_error", Error, 1);
        sendWord(32'h0101_0100);
        sendWord(32'hAAAA_AAAA);
        idle(2);
        check("hunt_ignores", FrameData, rowsT1);
        sendWord(SyncWord);

        // Back-to-back frames with random gaps; Error stays set but does not block
        sendFrame(8'd0, 8'd0, rowsA, 2, 32'h0);
        sendFrame(8'd3, 8'd31, rowsB, 2, 32'h0);
        idle(3);
        check("b2b_rows", FrameData, rowsB);
        check("error_sticky", Error, 1);

        // Reset after two data rows
        sendWord(32'h0101_0300);
        sendWord(rowsC[31:0]);
        sendWord(rowsC[63:32]);
        Rst = 1'b1;
        @(negedge UserCLK);
        check("midrst_ready", WriteReady, 0);
        Rst = 1'b0;
        @(negedge UserCLK);
        check("midrst_rows", FrameData, '0);
        check("midrst_error", Error, 0);
        sendWord(rowsC[95:64]);
        sendWord(rowsC[127:96]);
        idle(2);
        check("midrst_needs_sync", FrameData, '0);

`ifdef FRAME_LOADER_CHECKSUM_EN
        // Checksum match then mismatch (0F vs 0E)
        sendWord(SyncWord);
        sendFrame(8'd1, 8'd7, {32'h8, 32'h4, 32'h2, 32'h1}, 0, 32'h0);
        idle(2);
        check("csum_ok_error", Error, 0);
        sendFrame(8'd1, 8'd7, {32'h8, 32'h4, 32'h2, 32'h1}, 0, 32'h1);
        idle(2);
        check("csum_bad_error", Error, 1);
        check("csum_bad_rows", FrameData, {32'h8, 32'h4, 32'h2, 32'h1});
`endif

        idle(4);
        check("scoreboard_empty", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", numTests, numFails);
        $finish;
    end

endmodule
